seg7_scan_driver: RTL and testbench

Multiplexed N-digit seven-segment display driver for the board's common-anode displays. Accepts a packed hex value with per-digit decimal-point and blank masks, double-buffers it so that updates land only on frame boundaries, and scans the digits one at a time. Each digit slot begins with a guard interval to suppress ghosting. It sits between the machine core's status registers and the display pins, replacing the single-digit combinational hex decode with a time-multiplexed display path.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 139 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the seven-segment scan driver
package seg7_pkg;

    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam int         MAX_DIGITS = 8;

    // Active-low gfedcba patterns, entry 0 in the low slice.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - nibble to active-low gfedcba segment decode
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-buffered multiplexed seven-segment scanner
// Optional leading-zero blanking enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                  system1000,
    input  logic                  system1000_rstn,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_value_q, pend_value_d, act_value_q, act_value_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic                pend_valid_q, pend_valid_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;
    logic                frame_end;
    logic [DIGITS-1:0]   lzb_mask;
    logic [6:0]          hex_seg;
    logic                dark;

    always_comb begin
        frame_end    = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
        cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        if (cnt_q == CNT_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        // A load coinciding with frame end bypasses the pending slot entirely.
        if (frame_end) begin
            if (load) begin
                act_value_d = value;
                act_dp_d    = dp;
                act_blank_d = blank;
            end else if (pend_valid_q) begin
                act_value_d = pend_value_q;
                act_dp_d    = pend_dp_q;
                act_blank_d = pend_blank_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_value_d = value;
            pend_dp_d    = dp;
            pend_blank_d = blank;
            pend_valid_d = 1'b1;
        end
        frame_d = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
    end

`ifdef SEG7_LZB_EN
    logic zero_run;
    always_comb begin
        lzb_mask = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run && (act_value_d[4*i +: 4] == 4'h0);
            lzb_mask[i] = zero_run;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    seg7_hex_decode u_dec (
        .nibble (act_value_d[4*idx_d +: 4]),
        .seg_n  (hex_seg)
    );

    // Outputs are precomputed from next-state so the pins change with cnt/idx.
    always_comb begin
        dark  = act_blank_d[idx_d] | lzb_mask[idx_d] | (int'(cnt_d) < GUARD);
        an_d  = '1;
        seg_d = SEG_OFF;
        if (!dark) begin
            an_d  = ~(DIGITS'(1) << idx_d);
            seg_d = {~act_dp_d[idx_d], hex_seg};
        end
    end

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            seg_q        <= SEG_OFF;
            an_q         <= '1;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic        system1000;
    logic        system1000_rstn;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        load;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(8), .GUARD(2)) dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .value           (value),
        .dp              (dp),
        .blank           (blank),
        .load            (load),
        .seg             (seg),
        .an              (an),
        .frame           (frame)
    );

    initial system1000 = 1'b0;
    always #5 system1000 = ~system1000;

    // lit == 8'hFF marks a digit expected dark for its whole slot.
    function automatic logic [3:0] exp_an(int d, int c, logic [7:0] lit);
        if (c < 2 || lit == 8'hFF) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [7:0] exp_seg(int c, logic [7:0] lit);
        return (c < 2) ? 8'hFF : lit;
    endfunction

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        @(negedge system1000);
        value = v; dp = d; blank = b; load = 1'b1;
        @(negedge system1000);
        load = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            @(negedge system1000);
            n++;
        end while (frame !== 1'b1 && n < 40);
        checks++;
        if (frame !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_frame: no frame pulse within 40 cycles", name);
        end
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        logic [7:0] es;
        system1000_rstn = 1'b0; load = 1'b1; value = 16'hFFFF; dp = 4'hF; blank = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge system1000);
            checks++;
            if (an !== 4'hF || seg !== 8'hFF || frame !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: an=%b seg=%h frame=%b, expected an=1111 seg=ff frame=0", i, an, seg, frame);
            end
        end
        system1000_rstn = 1'b1; load = 1'b0; dp = 4'h0;
        for (int n = 1; n < 32; n++) begin
            @(negedge system1000);
            ea = exp_an(n / 8, n % 8, 8'hC0);
            es = exp_seg(n % 8, 8'hC0);
            checks++;
            if (an !== ea || seg !== es || frame !== (n == 31)) begin
                errors++;
                $display("FAIL post_reset n=%0d: an=%b seg=%h frame=%b, expected an=%b seg=%h frame=%b", n, an, seg, frame, ea, es, n == 31);
            end
        end
    endtask

    task automatic scan_expect(input string name, input logic [7:0] lit [4], input logic drop_load);
        logic [3:0] ea;
        logic [7:0] es;
        for (int s = 0; s < 32; s++) begin
            @(negedge system1000);
            if (drop_load && s == 0) load = 1'b0;
            ea = exp_an(s / 8, s % 8, lit[s / 8]);
            es = exp_seg(s % 8, lit[s / 8]);
            checks++;
            if (an !== ea || seg !== es || frame !== (s == 31)) begin
                errors++;
                $display("FAIL %s slot %0d: an=%b seg=%h frame=%b, expected an=%b seg=%h frame=%b", name, s, an, seg, frame, ea, es, s == 31);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [7:0] lit [4];
        lit = '{8'h99, 8'hA4, 8'hB0, 8'hF9};
        pulse_load(16'h1234, 4'h0, 4'h0);
        wait_frame("basic");
        lit = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        scan_expect("basic", lit, 1'b0);
    endtask

    task automatic test_dp();
        logic [7:0] lit [4];
        pulse_load(16'h1234, 4'b0010, 4'h0);
        wait_frame("dp");
        lit = '{8'h99, 8'h30, 8'hA4, 8'hF9};
        scan_expect("dp", lit, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] lit [4];
        repeat (5) @(negedge system1000);
        pulse_load(16'hAAAA, 4'h0, 4'h0);
        wait_frame("frame_end_load");
        value = 16'h5555; dp = 4'h0; blank = 4'h0; load = 1'b1;
        lit = '{8'h92, 8'h92, 8'h92, 8'h92};
        scan_expect("frame_end_load", lit, 1'b1);
        scan_expect("frame_end_load_hold", lit, 1'b0);
    endtask

    task automatic test_double_load();
        logic [7:0] lit [4];
        pulse_load(16'h1111, 4'h0, 4'h0);
        repeat (4) @(negedge system1000);
        pulse_load(16'h2222, 4'h0, 4'h0);
        wait_frame("double_load");
        lit = '{8'hA4, 8'hA4, 8'hA4, 8'hA4};
        scan_expect("double_load", lit, 1'b0);
    endtask

    task automatic test_blank();
        logic [7:0] lit [4];
        pulse_load(16'h8888, 4'h0, 4'b0100);
        wait_frame("blank");
        lit = '{8'h80, 8'h80, 8'hFF, 8'h80};
        scan_expect("blank", lit, 1'b0);
    endtask

    task automatic test_lzb();
        logic [7:0] lit [4];
        pulse_load(16'h0050, 4'h0, 4'h0);
        wait_frame("lzb_0050");
`ifdef SEG7_LZB_EN
        lit = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
`else
        lit = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
`endif
        scan_expect("lzb_0050", lit, 1'b0);
        pulse_load(16'h0000, 4'h0, 4'h0);
        wait_frame("lzb_0000");
`ifdef SEG7_LZB_EN
        lit = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
`else
        lit = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        scan_expect("lzb_0000", lit, 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] lit [4];
        logic [3:0] ea;
        logic [7:0] es;
        pulse_load(16'h9999, 4'hF, 4'h0);
        repeat (9) @(negedge system1000);
        pulse_load(16'h9999, 4'hF, 4'h0);
        system1000_rstn = 1'b0;
        @(negedge system1000);
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || frame !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: an=%b seg=%h frame=%b, expected an=1111 seg=ff frame=0", an, seg, frame);
        end
        system1000_rstn = 1'b1;
        for (int n = 1; n < 64; n++) begin
            @(negedge system1000);
            ea = exp_an((n / 8) % 4, n % 8, 8'hC0);
            es = exp_seg(n % 8, 8'hC0);
            checks++;
            if (an !== ea || seg !== es || frame !== (n == 31 || n == 63)) begin
                errors++;
                $display("FAIL mid_reset_after n=%0d: an=%b seg=%h frame=%b, expected an=%b seg=%h", n, an, seg, frame, ea, es);
            end
        end
        lit = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
        scan_expect("mid_reset_idle", lit, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_dp();
        test_back_to_back();
        test_double_load();
        test_blank();
        test_lzb();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
